// File: rtl/regbus2axi4lite.sv
`default_nettype none
// ============================================================================
// regbus2axi4lite : single-outstanding regbus to AXI4-Lite master bridge
// Revision 1.0 - initial release
// ============================================================================
module regbus2axi4lite #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 256
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                addr_valid,
  input  logic                reg_write,
  input  logic [ADDR_W-1:0]   reg_addr,
  input  logic [DATA_W-1:0]   reg_wdata,
  output logic                reg_ready,
  output logic [DATA_W-1:0]   reg_rdata,
  output logic                reg_err,
  output logic [ADDR_W-1:0]   awaddr,
  output logic [2:0]          awprot,
  output logic                awvalid,
  input  logic                awready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wvalid,
  input  logic                wready,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready,
  output logic [ADDR_W-1:0]   araddr,
  output logic [2:0]          arprot,
  output logic                arvalid,
  input  logic                arready,
  input  logic [DATA_W-1:0]   rdata,
  input  logic [1:0]          rresp,
  input  logic                rvalid,
  output logic                rready
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WRITE  = 3'd1,
    WAIT_B = 3'd2,
    READ   = 3'd3,
    WAIT_R = 3'd4,
    RESP   = 3'd5
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             timed_out;
  logic             abort;

  assign wstrb  = '1;
  assign awprot = 3'b000;
  assign arprot = 3'b000;

  assign timed_out = (TIMEOUT != 0) && (cnt == CNT_LAST);

  // A response arriving in the very cycle the budget expires still wins.
  assign abort = timed_out &&
                 ((state == WRITE) || (state == READ) ||
                  ((state == WAIT_B) && !bvalid) ||
                  ((state == WAIT_R) && !rvalid));

  always_ff @(posedge Clk) begin
    if (Rst) begin
      cnt <= '0;
    end else if (state == IDLE) begin
      cnt <= '0;
    end else if (cnt != '1) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= IDLE;
      awaddr    <= '0;
      awvalid   <= 1'b0;
      wdata     <= '0;
      wvalid    <= 1'b0;
      bready    <= 1'b0;
      araddr    <= '0;
      arvalid   <= 1'b0;
      rready    <= 1'b0;
      reg_ready <= 1'b0;
      reg_rdata <= '0;
      reg_err   <= 1'b0;
    end else if (abort) begin
      awvalid   <= 1'b0;
      wvalid    <= 1'b0;
      bready    <= 1'b0;
      arvalid   <= 1'b0;
      rready    <= 1'b0;
      reg_ready <= 1'b1;
      reg_rdata <= '0;
      reg_err   <= 1'b1;
      state     <= RESP;
    end else begin
      case (state)
        IDLE: begin
          if (addr_valid) begin
            if (reg_write) begin
              awaddr  <= reg_addr;
              wdata   <= reg_wdata;
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              state   <= WRITE;
            end else begin
              araddr  <= reg_addr;
              arvalid <= 1'b1;
              state   <= READ;
            end
          end
        end
        WRITE: begin
          // AW and W complete independently; leave once neither is pending.
          if (awvalid && awready) awvalid <= 1'b0;
          if (wvalid && wready)   wvalid  <= 1'b0;
          if ((!awvalid || awready) && (!wvalid || wready)) begin
            bready <= 1'b1;
            state  <= WAIT_B;
          end
        end
        WAIT_B: begin
          if (bvalid) begin
            bready    <= 1'b0;
            reg_ready <= 1'b1;
            reg_rdata <= '0;
            reg_err   <= (bresp != 2'b00);
            state     <= RESP;
          end
        end
        READ: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= WAIT_R;
          end
        end
        WAIT_R: begin
          if (rvalid) begin
            rready    <= 1'b0;
            reg_ready <= 1'b1;
            reg_rdata <= rdata;
            reg_err   <= (rresp != 2'b00);
            state     <= RESP;
          end
        end
        RESP: begin
          reg_ready <= 1'b0;
          reg_rdata <= '0;
          reg_err   <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
